// File: rtl/ir_nec_decoder.sv
// NEC infrared remote decoder.
// Measures mark/space durations of the synchronized receiver output in
// prescaled ticks, validates each phase against its timing window and
// assembles the 32-bit frame LSB-first. A completed frame is held on
// `command` with `ir_ready` until the consumer acknowledges it.
module ir_nec_decoder #(
  parameter int clk_hz         = 25000000,
  parameter int tick_hz        = 100000,
  parameter int lead_mark_min  = 400,
  parameter int lead_mark_max  = 1000,
  parameter int lead_space_min = 400,
  parameter int lead_space_max = 500,
  parameter int bit_mark_min   = 40,
  parameter int bit_mark_max   = 72,
  parameter int space0_min     = 40,
  parameter int space0_max     = 72,
  parameter int space1_min     = 140,
  parameter int space1_max     = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  input  logic        ack,
  output logic        ir_ready,
  output logic [31:0] command,
  output logic        overrun,
  output logic        frame_err
);

  // Prescaler geometry; a divide ratio of one gives a tick on every clock.
  localparam int DIV     = (clk_hz / tick_hz < 1) ? 1 : (clk_hz / tick_hz);
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  // Repeat-code leader space window (ticks).
  localparam int REP_SPACE_MIN = 200;
  localparam int REP_SPACE_MAX = 280;

  localparam logic [9:0] CNT_SAT = 10'd1023;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LEAD_MARK  = 3'd1;
  localparam logic [2:0] S_LEAD_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK   = 3'd3;
  localparam logic [2:0] S_BIT_SPACE  = 3'd4;
  localparam logic [2:0] S_STOP       = 3'd5;

  logic               sync1_r;
  logic               sync2_r;
  logic               prev_r;
  logic [PRESC_W-1:0] presc_r;
  logic [9:0]         cnt_r;
  logic [2:0]         state_r;
  logic [5:0]         bit_cnt_r;
  logic [31:0]        shift_r;
  logic               ir_ready_r;
  logic [31:0]        command_r;
  logic               overrun_r;
  logic               frame_err_r;

  logic               tick_s;
  logic               fall_s;
  logic               rise_s;
  logic               edge_s;
  logic               timeout_s;
  logic [2:0]         state_n_s;
  logic [5:0]         bit_cnt_n_s;
  logic [31:0]        shift_n_s;
  logic               commit_s;
  logic               err_s;

  // Inclusive window test of a measured phase duration.
  function automatic logic in_win(input logic [9:0] v, input int lo, input int hi);
    in_win = (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  // Longest legal duration of the phase currently being measured.
  function automatic int phase_max(input logic [2:0] st);
    case (st)
      S_LEAD_MARK:  phase_max = lead_mark_max;
      S_LEAD_SPACE: phase_max = lead_space_max;
      S_BIT_MARK:   phase_max = bit_mark_max;
      S_BIT_SPACE:  phase_max = space1_max;
      S_STOP:       phase_max = bit_mark_max;
      default:      phase_max = 1023;
    endcase
  endfunction

  assign tick_s    = (presc_r == PRESC_LAST);
  assign fall_s    = prev_r & ~sync2_r;
  assign rise_s    = ~prev_r & sync2_r;
  assign edge_s    = fall_s | rise_s;
  assign timeout_s = (state_r != S_IDLE) && (int'(cnt_r) > phase_max(state_r));

  // Two-flop synchronizer plus one delayed copy for edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= ir_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Free-running prescaler producing the measurement tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Phase duration counter: cleared on every edge, saturating tick count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 10'd0;
    end else if (edge_s) begin
      cnt_r <= 10'd0;
    end else if (tick_s && (cnt_r != CNT_SAT)) begin
      cnt_r <= cnt_r + 10'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Frame state machine: validates each ended phase and shifts in data bits.
  always_comb begin
    state_n_s   = state_r;
    bit_cnt_n_s = bit_cnt_r;
    shift_n_s   = shift_r;
    commit_s    = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (fall_s) begin
          state_n_s   = S_LEAD_MARK;
          bit_cnt_n_s = 6'd0;
          shift_n_s   = 32'h0;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_LEAD_MARK: begin
        if (edge_s) begin
          if (in_win(cnt_r, lead_mark_min, lead_mark_max)) begin
            state_n_s = S_LEAD_SPACE;
          end else begin
            state_n_s = S_IDLE;
            err_s     = 1'b1;
          end
        end else if (timeout_s) begin
          state_n_s = S_IDLE;
          err_s     = 1'b1;
        end else begin
          state_n_s = S_LEAD_MARK;
        end
      end
      S_LEAD_SPACE: begin
        if (edge_s) begin
          if (in_win(cnt_r, lead_space_min, lead_space_max)) begin
            state_n_s = S_BIT_MARK;
          end else if (in_win(cnt_r, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            // Repeat code: nothing to deliver, not an error either.
            state_n_s = S_IDLE;
          end else begin
            state_n_s = S_IDLE;
            err_s     = 1'b1;
          end
        end else if (timeout_s) begin
          state_n_s = S_IDLE;
          err_s     = 1'b1;
        end else begin
          state_n_s = S_LEAD_SPACE;
        end
      end
      S_BIT_MARK: begin
        if (edge_s) begin
          if (in_win(cnt_r, bit_mark_min, bit_mark_max)) begin
            state_n_s = S_BIT_SPACE;
          end else begin
            state_n_s = S_IDLE;
            err_s     = 1'b1;
          end
        end else if (timeout_s) begin
          state_n_s = S_IDLE;
          err_s     = 1'b1;
        end else begin
          state_n_s = S_BIT_MARK;
        end
      end
      S_BIT_SPACE: begin
        if (edge_s) begin
          if (in_win(cnt_r, space0_min, space0_max) || in_win(cnt_r, space1_min, space1_max)) begin
            // Short space is a 0, long space a 1; bits arrive LSB first.
            shift_n_s   = {in_win(cnt_r, space1_min, space1_max), shift_r[31:1]};
            bit_cnt_n_s = bit_cnt_r + 6'd1;
            if (bit_cnt_r == 6'd31) begin
              commit_s  = 1'b1;
              state_n_s = S_STOP;
            end else begin
              state_n_s = S_BIT_MARK;
            end
          end else begin
            state_n_s = S_IDLE;
            err_s     = 1'b1;
          end
        end else if (timeout_s) begin
          state_n_s = S_IDLE;
          err_s     = 1'b1;
        end else begin
          state_n_s = S_BIT_SPACE;
        end
      end
      S_STOP: begin
        // The stop mark is informational only; leave quietly either way.
        if (rise_s || timeout_s) begin
          state_n_s = S_IDLE;
        end else begin
          state_n_s = S_STOP;
        end
      end
      default: begin
        state_n_s = S_IDLE;
      end
    endcase
  end

  // Frame state, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= 6'd0;
      shift_r   <= 32'h0;
    end else begin
      state_r   <= state_n_s;
      bit_cnt_r <= bit_cnt_n_s;
      shift_r   <= shift_n_s;
    end
  end

  // Output holding register with acknowledge handshake and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_ready_r  <= 1'b0;
      command_r   <= 32'h0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overrun_r   <= commit_s & ir_ready_r;
      frame_err_r <= err_s;
      if (ir_ready_r && ack) begin
        ir_ready_r <= 1'b0;
      end else if (commit_s && !ir_ready_r) begin
        ir_ready_r <= 1'b1;
      end else begin
        ir_ready_r <= ir_ready_r;
      end
      if (commit_s && !ir_ready_r) begin
        command_r <= shift_n_s;
      end else begin
        command_r <= command_r;
      end
    end
  end

  assign ir_ready  = ir_ready_r;
  assign command   = command_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed plus randomized bench for ir_nec_decoder. The clock is set equal
// to the tick rate so one tick is one clock, keeping full frames short.
module tb_ir_nec_decoder;

  logic        clk;
  logic        rst;
  logic        ir_in;
  logic        ack;
  logic        ir_ready;
  logic [31:0] command;
  logic        overrun;
  logic        frame_err;

  int checks;
  int errors;

  // Frame-level reference model state.
  logic        exp_ready;
  logic [31:0] exp_cmd;
  int          exp_ovr;
  int          exp_err;
  logic        exp_load;

  // Observed event bookkeeping.
  int  ovr_seen;
  int  err_seen;
  time err_t;
  time rise_t;
  time fall_t;
  logic ready_q;

  ir_nec_decoder #(
    .clk_hz  (100000),
    .tick_hz (100000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ir_in     (ir_in),
    .ack       (ack),
    .ir_ready  (ir_ready),
    .command   (command),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      err_seen = err_seen + 1;
      err_t    = $time;
    end
    if (overrun === 1'b1) ovr_seen = ovr_seen + 1;
    if (ir_ready === 1'b1 && ready_q === 1'b0) rise_t = $time;
    ready_q = ir_ready;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk32({tag, "_ready"}, {31'd0, ir_ready}, {31'd0, exp_ready});
    chk32({tag, "_cmd"}, command, exp_cmd);
    chk32({tag, "_ovr"}, ovr_seen, exp_ovr);
    chk32({tag, "_err"}, err_seen, exp_err);
  endtask

  task automatic mark(input int n);
    ir_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic space(input int n);
    ir_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    mark(int'($urandom_range(68, 45)));
    if (b) space(int'($urandom_range(195, 145)));
    else   space(int'($urandom_range(68, 45)));
  endtask

  task automatic send_frame(input logic [31:0] v, input int lead_mark);
    mark(lead_mark);
    space(450);
    for (int i = 0; i < 32; i++) send_bit(v[i]);
    fall_t = $time;
    mark(56);
    space(300);
  endtask

  // Reference rule for a completed frame: load if empty, otherwise drop it.
  task automatic model_frame(input logic [31:0] v);
    exp_load = ~exp_ready;
    if (!exp_ready) begin
      exp_ready = 1'b1;
      exp_cmd   = v;
    end else begin
      exp_ovr = exp_ovr + 1;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    exp_ready = 1'b0;
    chk32("ack_clears", {31'd0, ir_ready}, 32'd0);
  endtask

  task automatic frame_and_check(input string tag, input logic [31:0] v, input int lead_mark);
    rise_t = 0;
    send_frame(v, lead_mark);
    model_frame(v);
    check_state(tag);
    if (exp_load) begin
      chk32({tag, "_latency"}, {31'd0, (rise_t > fall_t) && (rise_t - fall_t <= 50)}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] v;
    time t0;
    checks = 0; errors = 0;
    exp_ready = 1'b0; exp_cmd = 32'h0; exp_ovr = 0; exp_err = 0; exp_load = 1'b0;
    ovr_seen = 0; err_seen = 0; err_t = 0; rise_t = 0; fall_t = 0; ready_q = 1'b0;
    rst = 1'b1; ir_in = 1'b1; ack = 1'b0;
    repeat (4) @(negedge clk);
    chk32("rst_ready", {31'd0, ir_ready}, 32'd0);
    chk32("rst_cmd", command, 32'h0);
    chk32("rst_ovr", {31'd0, overrun}, 32'd0);
    chk32("rst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Standard frame with 9 ms leader.
    frame_and_check("std_frame", 32'hFE010707, 900);
    do_ack();

    // Short 4.5 ms leader mark is still within the window.
    frame_and_check("short_lead", 32'hFE010707, 450);

    // Second frame while the first is unacknowledged is dropped.
    frame_and_check("overrun", 32'hFD020707, 900);
    chk32("overrun_keep", command, 32'hFE010707);
    do_ack();

    // Acknowledge with nothing pending has no effect.
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk32("ack_idle", {31'd0, ir_ready}, 32'd0);

    // Bit 10 with a 1.2 ms space is rejected.
    v = 32'hFE010707;
    mark(900); space(450);
    for (int i = 0; i < 9; i++) send_bit(v[i]);
    mark(56); space(120); mark(56); space(300);
    exp_err = exp_err + 1;
    check_state("bad_space");

    // Truncated frame: the space after the 21st mark never ends.
    mark(900); space(450);
    for (int i = 0; i < 20; i++) send_bit(v[i]);
    mark(56);
    t0 = $time;
    space(400);
    exp_err = exp_err + 1;
    check_state("truncated");
    chk32("trunc_timing", {31'd0, (err_t >= t0 + 2000) && (err_t <= t0 + 2100)}, 32'd1);

    // Repeat code is silent.
    mark(900); space(225); mark(56); space(400);
    check_state("repeat");

    // Reset mid-frame, then a clean frame.
    v = 32'h9F600707;
    mark(900); space(450);
    for (int i = 0; i < 16; i++) send_bit(v[i]);
    mark(56);
    ir_in = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_ready = 1'b0;
    exp_cmd   = 32'h0;
    space(300);
    check_state("mid_rst");
    frame_and_check("after_rst", 32'h9F600707, 900);

    // Randomized frames with random acknowledge behaviour.
    for (int r = 0; r < 2; r++) begin
      if ($urandom_range(1, 0) == 1) begin
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        exp_ready = 1'b0;
      end
      frame_and_check("rand_frame", $urandom, int'($urandom_range(950, 450)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
